// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;
    localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int width = 19,
    parameter int n     = 6
);

    logic             start;
    logic [width-1:0] bin_in;
    logic             busy;
    logic             done;
    logic [4*n-1:0]   bcd_out;
    logic             ovf;
    logic             neg;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, ovf, neg
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, ovf, neg
    );

endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit adjust: a digit of 5 or more gets 3 added before the shift.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin_in as two's complement and report the sign on neg.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int width = 19,
    parameter int n     = 6
) (
    input  logic         clk,
    input  logic         reset,
    bin2bcd_seq_if.slave bus
);

    localparam int AW = 4 * n;
    localparam int CW = (width > 1) ? $clog2(width) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(width - 1);
    localparam logic [AW-1:0] ALL_NINES = {n{BCD_MAX_DIGIT}};

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [width-1:0] bin_q, bin_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [AW-1:0]    bcd_q, bcd_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             accept;
    logic             last_shift;
    logic             busy;
    logic [AW-1:0]    acc_adj;
    logic [AW-1:0]    acc_shifted;
    logic             carry_out;
    logic [width-1:0] mag;

    for (genvar g = 0; g < n; g++) begin : g_adj
        bcd_add3 u_add3 (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (acc_adj[4*g +: 4])
        );
    end

    // A 1 leaving the top digit means the value no longer fits in n digits.
    assign carry_out   = acc_adj[AW-1];
    assign acc_shifted = {acc_adj[AW-2:0], bin_q[width-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept     = 1'b0;
        last_shift = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE:  accept = bus.start;
            SHIFT: begin
                busy       = 1'b1;
                last_shift = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d    = acc_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        if (accept) begin
            acc_d    = '0;
            bin_d    = mag;
            cnt_d    = CNT_LAST;
            sticky_d = 1'b0;
        end else if (busy) begin
            acc_d    = acc_shifted;
            bin_d    = {bin_q[width-2:0], 1'b0};
            sticky_d = sticky_q | carry_out;
            if (last_shift) begin
                cnt_d  = '0;
                done_d = 1'b1;
                ovf_d  = sticky_d;
                bcd_d  = sticky_d ? ALL_NINES : acc_shifted;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

`ifdef BIN2BCD_SIGNED_EN
    logic sign_q, sign_d;
    logic neg_q, neg_d;

    // Negating the most negative value wraps to 2^(width-1), which is its true magnitude.
    assign mag = bus.bin_in[width-1] ? -bus.bin_in : bus.bin_in;

    always_comb begin
        sign_d = sign_q;
        neg_d  = neg_q;
        if (accept) begin
            sign_d = bus.bin_in[width-1];
        end
        if (last_shift) begin
            neg_d = sign_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            sign_q <= sign_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.neg = neg_q;
`else
    assign mag     = bus.bin_in;
    assign bus.neg = 1'b0;
`endif

    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;

endmodule
